// File: rtl/ahb_axi_wr_sched.sv
// Write-path scheduler feeding the AXI AW/W/B channels from one burst descriptor at a time.
// Tracks bursts awaiting a B response and raises a sticky error flag.
module ahb_axi_wr_sched #(
  parameter int AW        = 32,
  parameter int DW        = 64,
  parameter int TIDW      = 1,
  parameter int MAX_OUTST = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DW-1:0]     wd_data,
  input  logic [DW/8-1:0]   wd_strb,
  output logic [TIDW-1:0]   axi_aw_id_o,
  output logic [AW-1:0]     axi_aw_addr_o,
  output logic [7:0]        axi_aw_len_o,
  output logic [2:0]        axi_aw_size_o,
  output logic [1:0]        axi_aw_burst_o,
  output logic              axi_aw_valid_o,
  input  logic              axi_aw_ready_i,
  output logic [DW-1:0]     axi_w_data_o,
  output logic [DW/8-1:0]   axi_w_strb_o,
  output logic              axi_w_last_o,
  output logic              axi_w_valid_o,
  input  logic              axi_w_ready_i,
  input  logic [TIDW-1:0]   axi_b_id_i,
  input  logic [1:0]        axi_b_resp_i,
  input  logic              axi_b_valid_i,
  output logic              axi_b_ready_o,
  output logic [3:0]        outst_o,
  output logic              idle_o,
  output logic              err_o,
  input  logic              err_clr_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [AW-1:0]   aw_addr_r;
  logic [7:0]      aw_len_r;
  logic [2:0]      aw_size_r;
  logic [1:0]      aw_burst_r;
  logic            aw_valid_r;
  logic [7:0]      beat_cnt_r;
  logic [3:0]      outst_r;
  logic            err_r;
  logic            cmd_hs_s, aw_hs_s, w_hs_s, b_hs_s, err_set_s;
  logic            unused_s;

  // BID is not checked: every AW is issued with ID 0.
  assign unused_s = ^axi_b_id_i;

  assign cmd_hs_s  = cmd_valid & cmd_ready;
  assign aw_hs_s   = aw_valid_r & axi_aw_ready_i;
  assign w_hs_s    = axi_w_valid_o & axi_w_ready_i;
  assign b_hs_s    = axi_b_valid_i & axi_b_ready_o;
  assign err_set_s = (cmd_hs_s & (cmd_burst == 2'b11)) | (b_hs_s & (axi_b_resp_i != 2'b00));

  assign axi_aw_id_o    = {TIDW{1'b0}};
  assign axi_aw_addr_o  = aw_addr_r;
  assign axi_aw_len_o   = aw_len_r;
  assign axi_aw_size_o  = aw_size_r;
  assign axi_aw_burst_o = aw_burst_r;
  assign axi_aw_valid_o = aw_valid_r;
  assign axi_b_ready_o  = (outst_r != 4'd0);
  assign outst_o        = outst_r;
  assign idle_o         = (state_r == IDLE) && (outst_r == 4'd0);
  assign err_o          = err_r;

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and channel handshake outputs; cmd_ready is held low while reset is applied.
  always_comb begin
    state_nxt_s   = state_r;
    cmd_ready     = 1'b0;
    wd_ready      = 1'b0;
    axi_w_valid_o = 1'b0;
    axi_w_last_o  = 1'b0;
    axi_w_data_o  = {DW{1'b0}};
    axi_w_strb_o  = {(DW/8){1'b0}};
    case (state_r)
      IDLE: begin
        cmd_ready = HRESETn & (outst_r < 4'(MAX_OUTST));
        if (cmd_valid && HRESETn && (outst_r < 4'(MAX_OUTST))) begin
          state_nxt_s = ADDR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ADDR: begin
        if (aw_valid_r && axi_aw_ready_i) begin
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = ADDR;
        end
      end
      DATA: begin
        wd_ready      = axi_w_ready_i;
        axi_w_valid_o = wd_valid;
        axi_w_data_o  = wd_data;
        axi_w_strb_o  = wd_strb;
        axi_w_last_o  = (beat_cnt_r == aw_len_r);
        if (wd_valid && axi_w_ready_i && (beat_cnt_r == aw_len_r)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DATA;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // AW request register; a reserved burst type is issued as INCR.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      aw_addr_r  <= {AW{1'b0}};
      aw_len_r   <= 8'd0;
      aw_size_r  <= 3'd0;
      aw_burst_r <= 2'b00;
      aw_valid_r <= 1'b0;
    end else if (cmd_hs_s) begin
      aw_addr_r  <= cmd_addr;
      aw_len_r   <= cmd_len;
      aw_size_r  <= cmd_size;
      aw_burst_r <= (cmd_burst == 2'b11) ? 2'b01 : cmd_burst;
      aw_valid_r <= 1'b1;
    end else if (aw_hs_s) begin
      aw_valid_r <= 1'b0;
    end
  end

  // Beat counter, outstanding-burst counter and sticky error flag.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      beat_cnt_r <= 8'd0;
      outst_r    <= 4'd0;
      err_r      <= 1'b0;
    end else begin
      if (aw_hs_s) begin
        beat_cnt_r <= 8'd0;
      end else if (w_hs_s) begin
        beat_cnt_r <= beat_cnt_r + 8'd1;
      end
      if (aw_hs_s && !b_hs_s && (outst_r < 4'(MAX_OUTST))) begin
        outst_r <= outst_r + 4'd1;
      end else if (b_hs_s && !aw_hs_s && (outst_r != 4'd0)) begin
        outst_r <= outst_r - 4'd1;
      end
      if (err_set_s) begin
        err_r <= 1'b1;
      end else if (err_clr_i) begin
        err_r <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ahb_axi_wr_sched.md
Name: ahb_axi_wr_sched

Overview:
Write-path scheduler between the AHB-to-AXI bridge front end and the AXI write channels (AW/W/B).
- Accepts one burst descriptor at a time and issues its AW request, then streams exactly LEN+1 W beats with correct WLAST.
- Tracks outstanding B responses up to a programmable limit and flags error responses.
- One instance sits in the bridge in front of the AXI slave port.

Parameters:
AW, 32, address width
DW, 64, data width (multiple of 8)
TIDW, 1, AXI ID width
MAX_OUTST, 4, max bursts awaiting B response (1..15)

Ports:
HCLK  in  1  clock
HRESETn  in  1  async active-low reset
cmd_valid  in  1  burst descriptor valid
cmd_ready  out  1  descriptor accepted
cmd_addr  in  AW  start address
cmd_len  in  8  beats-1
cmd_size  in  3  AXI size
cmd_burst  in  2  AXI burst type
wd_valid  in  1  write beat valid
wd_ready  out  1  write beat accepted
wd_data  in  DW  beat data
wd_strb  in  DW/8  beat strobes
axi_aw_id_o  out  TIDW  AWID
axi_aw_addr_o  out  AW  AWADDR
axi_aw_len_o  out  8  AWLEN
axi_aw_size_o  out  3  AWSIZE
axi_aw_burst_o  out  2  AWBURST
axi_aw_valid_o  out  1  AWVALID
axi_aw_ready_i  in  1  AWREADY
axi_w_data_o  out  DW  WDATA
axi_w_strb_o  out  DW/8  WSTRB
axi_w_last_o  out  1  WLAST
axi_w_valid_o  out  1  WVALID
axi_w_ready_i  in  1  WREADY
axi_b_id_i  in  TIDW  BID
axi_b_resp_i  in  2  BRESP
axi_b_valid_i  in  1  BVALID
axi_b_ready_o  out  1  BREADY
outst_o  out  4  bursts awaiting B
idle_o  out  1  IDLE state and outst_o==0
err_o  out  1  sticky error flag
err_clr_i  in  1  clears err_o

Behaviour:
Clock and reset:
- Single clock HCLK; reset HRESETn is asynchronous, active-low.
- All outputs are 0 in reset except idle_o=1; the state machine resets to IDLE.

States and transitions (IDLE, ADDR, DATA):
- IDLE: cmd_ready = (outst < MAX_OUTST). A cmd_valid&cmd_ready handshake registers the AW fields and moves to ADDR. axi_aw_valid_o is 1 starting the cycle after acceptance.
- ADDR: AW fields and axi_aw_valid_o stay stable until axi_aw_ready_i. On that handshake, outst increments, beat counter is cleared, and the state moves to DATA.
- DATA:
  - axi_w_valid_o = wd_valid; wd_ready = axi_w_ready_i.
  - data and strb pass through combinationally.
  - axi_w_last_o = (beat_cnt == registered len).
  - Each W handshake increments beat_cnt. The handshake with last=1 returns to IDLE.
  - Outside DATA: wd_ready=0 and axi_w_valid_o=0.

AW field rules:
- axi_aw_id_o is tied to 0.
- cmd_burst=2'b11 (reserved) is issued as INCR (2'b01) and sets err_o.
- cmd_len=0 gives a single beat with WLAST on the first beat.

B channel and outstanding count:
- axi_b_ready_o = (outst != 0).
- A B handshake decrements outst. If AW and B handshakes happen in the same cycle, outst is unchanged.
- outst never exceeds MAX_OUTST and never underflows.
- BRESP != 0 on a handshake sets err_o.

Error flag:
- err_o is sticky.
- err_clr_i clears it; a set in the same cycle as a clear wins.

Back-pressure and reset timing:
- W data is never buffered; back-pressure propagates directly from WREADY.
- Reset mid-burst aborts immediately: state returns to IDLE, outst returns to 0, and no further beats are issued.

Test Plan:
- Single beat: cmd len=0, addr=0x100, burst INCR, AWREADY immediate -> AWVALID one cycle after accept, one W beat with WLAST=1, BRESP=0 -> outst 1→0, idle_o=1, err_o=0.
- 4-beat burst with WREADY toggling 1,0,1,0,… -> exactly 4 handshakes, WLAST only on the 4th, data order preserved.
- MAX_OUTST=4, BVALID held low, 5 commands -> 4 AW issued, cmd_ready=0 for the 5th. One B handshake then reopens cmd_ready.
- AW handshake in the same cycle as a B handshake with outst=2 -> outst stays 2.
- BRESP=2'b10 -> err_o=1 and stays 1. err_clr_i pulse -> 0. cmd_burst=2'b11 -> AWBURST=2'b01 and err_o=1.
- HRESETn asserted during beat 2 of 8 -> all outputs 0 immediately (idle_o=1), outst=0. After reset release, a new cmd is accepted normally.
